// File: rtl/int_ctrl_pkg.sv
// Shared register map and per-bit detect-mode encodings for the interrupt controller.
package int_ctrl_pkg;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_MODE     = 3'd2;
    localparam logic [2:0] ADDR_RAW      = 3'd3;
    localparam logic [2:0] ADDR_COAL_THR = 3'd4;
    localparam logic [2:0] ADDR_COAL_TMO = 3'd5;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

endpackage

// File: rtl/int_coalesce.sv
// Interrupt coalescing: event counter and pending timer, threshold/timeout compare, irq hold.
module int_coalesce #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] thr_i,
    input  logic [CNT_W-1:0] tmo_i,
    input  logic             new_evt,
    input  logic             any_pend,
    output logic             irq_fire
);

    logic [CNT_W-1:0] ev_cnt_q, ev_cnt_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] thr_eff;
    logic             irq_q, irq_d;

    always_comb begin
        thr_eff  = (thr_i == '0) ? CNT_W'(1) : thr_i;
        ev_cnt_d = '0;
        tmr_d    = '0;
        irq_d    = 1'b0;
        // any_pend is next-cycle masked pending, so irq drops on the same edge STATUS empties.
        // tmr is compared before its update, which places the timeout exactly TMO cycles
        // after pending becomes visible.
        if (any_pend) begin
            ev_cnt_d = ev_cnt_q;
            if (new_evt && (ev_cnt_q != '1)) begin
                ev_cnt_d = ev_cnt_q + CNT_W'(1);
            end
            tmr_d = tmr_q;
            if (!irq_q && (tmr_q != '1)) begin
                tmr_d = tmr_q + CNT_W'(1);
            end
            irq_d = irq_q || (ev_cnt_d >= thr_eff) || ((tmo_i != '0) && (tmr_q >= tmo_i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_cnt_q <= '0;
            tmr_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            ev_cnt_q <= ev_cnt_d;
            tmr_q    <= tmr_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_fire = irq_q;

endmodule

// File: rtl/int_ctrl_reg.sv
// Interrupt status/mask/mode register block with per-bit edge/level detect and W1C status.
// Optional event coalescing on irq_o is enabled by defining INT_COALESCE_EN.
module int_ctrl_reg
    import int_ctrl_pkg::*;
#(
    parameter int unsigned     DW       = 8,
    parameter logic [DW-1:0]   RST_MASK = '0,
    parameter logic [DW-1:0]   RST_MODE = '0,
    parameter int unsigned     CNT_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpuren_i,
    input  logic          cpuwen_i,
    input  logic [2:0]    cpuaddr_i,
    input  logic [DW-1:0] cpudi_i,
    output logic [DW-1:0] cpudo_o,
    input  logic [DW-1:0] status_i,
    input  logic          clr_i,
    output logic [DW-1:0] pend_o,
    output logic          irq_o
);

    logic [DW-1:0]    status_q, status_d;
    logic [DW-1:0]    mask_q, mask_d;
    logic [DW-1:0]    mode_q, mode_d;
    logic [DW-1:0]    sts_d_q;
    logic [DW-1:0]    evt;
    logic [DW-1:0]    clrmask;
    logic [DW-1:0]    pend_next;
    logic [DW-1:0]    rd_data;
    logic [CNT_W-1:0] thr_rd, tmo_rd;

    always_comb begin
        evt = '0;
        for (int unsigned i = 0; i < DW; i++) begin
            evt[i] = (mode_q[i] == MODE_EDGE) ? (status_i[i] & ~sts_d_q[i]) : status_i[i];
        end
        clrmask = '0;
        if (cpuwen_i && (cpuaddr_i == ADDR_STATUS)) clrmask = cpudi_i;
        if (clr_i) clrmask = '1;
        status_d  = (status_q & ~clrmask) | evt;
        mask_d    = (cpuwen_i && (cpuaddr_i == ADDR_MASK)) ? cpudi_i : mask_q;
        mode_d    = (cpuwen_i && (cpuaddr_i == ADDR_MODE)) ? cpudi_i : mode_q;
        pend_next = status_d & mask_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
            mask_q   <= RST_MASK;
            mode_q   <= RST_MODE;
            sts_d_q  <= '0;
        end else begin
            status_q <= status_d;
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            sts_d_q  <= status_i;
        end
    end

    assign pend_o = status_q & mask_q;

`ifdef INT_COALESCE_EN
    logic [CNT_W-1:0] thr_q, thr_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             irq_fire;

    always_comb begin
        thr_d = (cpuwen_i && (cpuaddr_i == ADDR_COAL_THR)) ? cpudi_i[CNT_W-1:0] : thr_q;
        tmo_d = (cpuwen_i && (cpuaddr_i == ADDR_COAL_TMO)) ? cpudi_i[CNT_W-1:0] : tmo_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            thr_q <= CNT_W'(1);
            tmo_q <= '0;
        end else begin
            thr_q <= thr_d;
            tmo_q <= tmo_d;
        end
    end

    // Unmasking an already-latched bit counts as a new event so it can re-raise irq.
    int_coalesce #(
        .CNT_W (CNT_W)
    ) u_coalesce (
        .clk      (clk),
        .rst      (rst),
        .thr_i    (thr_q),
        .tmo_i    (tmo_q),
        .new_evt  (|(pend_next & ~pend_o)),
        .any_pend (|pend_next),
        .irq_fire (irq_fire)
    );

    assign thr_rd = thr_q;
    assign tmo_rd = tmo_q;
    assign irq_o  = irq_fire;
`else
    logic irq_q, irq_d;

    always_comb begin
        irq_d = |pend_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign thr_rd = '0;
    assign tmo_rd = '0;
    assign irq_o  = irq_q;
`endif

    always_comb begin
        rd_data = '0;
        case (cpuaddr_i)
            ADDR_STATUS:   rd_data = status_q;
            ADDR_MASK:     rd_data = mask_q;
            ADDR_MODE:     rd_data = mode_q;
            ADDR_RAW:      rd_data = status_i;
            ADDR_COAL_THR: rd_data[CNT_W-1:0] = thr_rd;
            ADDR_COAL_TMO: rd_data[CNT_W-1:0] = tmo_rd;
            default:       rd_data = '0;
        endcase
        cpudo_o = cpuren_i ? rd_data : '0;
    end

endmodule
